// File: rtl/riscv_pkg.sv
// Shared integer-core constants used by decode, writeback and the register file.
//   XLEN     : data width
//   NREG     : number of architectural registers (x0 included)
//   AW       : register address width, clog2(NREG)
//   PEND_W   : width of a per-register pending-write counter
//   REG_ZERO : address of the hardwired-zero register
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int PEND_W = 2;

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/sb_counter.sv
// One pending-write counter of the scoreboard.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : a writer to this register is issued this cycle
//   dec        : a writer to this register reaches writeback this cycle
//   cnt        : current number of in-flight writers
//   nonzero    : cnt != 0
//   err        : combinational pulse when an inc would overflow or a dec would underflow
module sb_counter #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              nonzero,
    output logic              err
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic inc_only;
    logic dec_only;

    // A simultaneous issue and writeback cancel out.
    assign inc_only = inc && !dec;
    assign dec_only = dec && !inc;

    assign nonzero = (cnt != '0);
    assign err     = (inc_only && (cnt == CNT_MAX)) || (dec_only && (cnt == '0));

    // Saturate at both ends; the error pulse records the lost event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc_only && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end else if (dec_only && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with a pending-write scoreboard (writeback sink).
//   clk, rst_n         : clock, asynchronous active-low reset
//   rs1_addr, rs2_addr : read addresses from decode
//   rs1_used, rs2_used : decode consumes the operand
//   rs1_data, rs2_data : combinational read data, with same-cycle WB bypass
//   stall              : RAW hazard on a consumed operand
//   iss_en, iss_rd     : instruction leaving decode writes iss_rd
//   wb_en, wb_rd       : writeback valid and destination
//   wb_data            : writeback result
//   sb_err             : sticky counter overflow/underflow flag
module reg_file_sb
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int NREG   = riscv_pkg::NREG,
    parameter int AW     = riscv_pkg::AW,
    parameter int PEND_W = riscv_pkg::PEND_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rs1_used,
    input  logic            rs2_used,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            stall,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            sb_err
);

    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [XLEN-1:0]              regs [NREG];
    logic [NREG-1:0][PEND_W-1:0]  cnt;
    logic [NREG-1:0]              nz;
    logic [NREG-1:0]              err_p;

    logic byp1, byp2;
    logic busy1, busy2;

    // x0 never has writers, so its counter slot is tied off.
    assign cnt[0]   = '0;
    assign nz[0]    = 1'b0;
    assign err_p[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (iss_en && (iss_rd == AW'(r))),
            .dec     (wb_en && (wb_rd == AW'(r))),
            .cnt     (cnt[r]),
            .nonzero (nz[r]),
            .err     (err_p[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (wb_en && (wb_rd != REG_ZERO)) begin
                regs[wb_rd] <= wb_data;
            end
            if (|err_p) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign byp1 = wb_en && (wb_rd == rs1_addr);
    assign byp2 = wb_en && (wb_rd == rs2_addr);

    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == REG_ZERO) begin
            rs1_data = '0;
        end else if (byp1) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == REG_ZERO) begin
            rs2_data = '0;
        end else if (byp2) begin
            rs2_data = wb_data;
        end
    end

    // The last outstanding writer arriving at WB this cycle is forwarded
    // by the bypass, so the operand is already available.
    assign busy1 = nz[rs1_addr] && !((cnt[rs1_addr] == CNT_ONE) && byp1);
    assign busy2 = nz[rs2_addr] && !((cnt[rs2_addr] == CNT_ONE) && byp2);

    assign stall = (rs1_used && busy1) || (rs2_used && busy2);

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_used, rs2_used;
    logic [31:0] rs1_data, rs2_data;
    logic        stall;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        sb_err;

    int n_vec = 0;
    int n_bad = 0;

    reg_file_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .stall    (stall),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .sb_err   (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        u1;
        logic        u2;
        logic        ie;
        logic [4:0]  ir;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        es;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                         input logic ie, input logic [4:0] ir, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd);
        rs1_addr = a1; rs2_addr = a2; rs1_used = u1; rs2_used = u2;
        iss_en = ie; iss_rd = ir; wb_en = we; wb_rd = wr; wb_data = wd;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            drive(5'(i), 5'(31 - i), 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
            #1;
            chk({tag, "_rs1"}, rs1_data, 32'h0);
            chk({tag, "_rs2"}, rs2_data, 32'h0);
            chk({tag, "_stall"}, {31'b0, stall}, 32'h0);
        end
        chk({tag, "_err"}, {31'b0, sb_err}, 32'h0);
    endtask

    initial begin
        // a1 a2 u1 u2 ie ir we wr wd | e1 e2 stall
        vt.push_back('{5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b0});
        vt.push_back('{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b0});
        vt.push_back('{5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0});
        vt.push_back('{5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0});
        vt.push_back('{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b0});
        vt.push_back('{5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 32'h11,       32'h0,        32'h11,       1'b0});
        vt.push_back('{5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0,        32'h0,        32'h11,       1'b0});
        vt.push_back('{5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 1'b0});
        vt.push_back('{5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        32'hA5A5A5A5, 1'b0});
        vt.push_back('{5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 32'h1234,     32'h0,        32'h0,        1'b0});
        vt.push_back('{5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        32'hDEADBEEF, 1'b0});
        vt.push_back('{5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b0});
        vt.push_back('{5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b1});
        vt.push_back('{5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b0});
        vt.push_back('{5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b1});
        vt.push_back('{5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hCAFE0003, 32'hCAFE0003, 32'hCAFE0003, 1'b0});
        vt.push_back('{5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'hCAFE0003, 32'h0,        1'b0});
        vt.push_back('{5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b0});
        vt.push_back('{5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b1});
        vt.push_back('{5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99,       32'h99,       32'h0,        1'b1});
        vt.push_back('{5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h9A,       32'h9A,       32'h0,        1'b0});
        vt.push_back('{5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h9A,       32'h9A,       1'b1});
        vt.push_back('{5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 32'h9B,       32'h0,        32'h9B,       1'b0});
        vt.push_back('{5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h9B,       32'h9B,       1'b0});

        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        read_all_zero("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        cycle();

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].a1, vt[i].a2, vt[i].u1, vt[i].u2, vt[i].ie, vt[i].ir, vt[i].we, vt[i].wr, vt[i].wd);
            #1;
            chk($sformatf("v%0d_rs1", i), rs1_data, vt[i].e1);
            chk($sformatf("v%0d_rs2", i), rs2_data, vt[i].e2);
            chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vt[i].es});
            chk($sformatf("v%0d_err", i), {31'b0, sb_err}, 32'h0);
            cycle();
        end

        // Overflow: four issues to x4 saturate at 3 and set sb_err.
        for (int k = 0; k < 4; k++) begin
            drive(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0);
            #1;
            chk($sformatf("ovf_err_pre%0d", k), {31'b0, sb_err}, 32'h0);
            cycle();
        end
        drive(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("ovf_err", {31'b0, sb_err}, 32'h1);
        chk("ovf_stall", {31'b0, stall}, 32'h1);
        for (int k = 0; k < 2; k++) begin
            drive(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h40 + k);
            #1;
            chk($sformatf("ovf_wb%0d_stall", k), {31'b0, stall}, 32'h1);
            cycle();
        end
        drive(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("ovf_cnt1_stall", {31'b0, stall}, 32'h1);
        drive(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h42);
        #1;
        chk("ovf_last_stall", {31'b0, stall}, 32'h0);
        chk("ovf_last_data", rs1_data, 32'h42);
        cycle();
        drive(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("ovf_done_stall", {31'b0, stall}, 32'h0);
        chk("ovf_sticky", {31'b0, sb_err}, 32'h1);

        // Mid-run asynchronous reset with a pending writer on x9.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
        cycle();
        drive(5'd9, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("pre_rst_stall", {31'b0, stall}, 32'h1);
        chk("pre_rst_x5", rs2_data, 32'hDEADBEEF);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", {31'b0, stall}, 32'h0);
        chk("mid_rst_x5", rs2_data, 32'h0);
        chk("mid_rst_x9", rs1_data, 32'h0);
        chk("mid_rst_err", {31'b0, sb_err}, 32'h0);
        read_all_zero("rst1");
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        cycle();

        // Underflow: WB to x6 with no writer pending still writes x6.
        drive(5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6, 32'h66);
        #1;
        chk("unf_byp", rs1_data, 32'h66);
        chk("unf_err_pre", {31'b0, sb_err}, 32'h0);
        cycle();
        drive(5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("unf_err", {31'b0, sb_err}, 32'h1);
        chk("unf_data", rs1_data, 32'h66);
        chk("unf_stall", {31'b0, stall}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
